seg_execute_alu_arbiter: RTL and testbench
==========================================

# seg_execute_alu_arbiter

Shares the single execute-stage ALU (`seg_execute_alu`) between two requesters: port 0 is the pipeline execute path and port 1 is the debug/auxiliary path. Each port uses a valid/grant request handshake. The block arbitrates round-robin, drives the shared combinational ALU, and captures the outcome in a one-deep result register. That register carries the requester tag and uses a valid/ready output handshake. The block sits between the ID/EX pipeline register and the EX/MEM writeback of the MIPS core.

## Interface
- `LEN`, 32, operand/result width
- `NB_ALUCTL`, 4, ALU control width (`seg_execute_alu` encoding)

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_req_0` / `i_req_1`  in  1  request valid, port 0 / port 1
- `i_ALUctl_0` / `i_ALUctl_1`  in  NB_ALUCTL  operation per port
- `i_data_a_0` / `i_data_a_1`  in  LEN  operand A per port
- `i_data_b_0` / `i_data_b_1`  in  LEN  operand B / shift amount per port
- `o_gnt_0` / `o_gnt_1`  out  1  grant; the request is consumed on this edge
- `o_valid`  out  1  result register holds an unconsumed result
- `o_result`  out  LEN  registered ALUOut
- `o_zero`  out  1  registered zero flag (`o_result == 0`)
- `o_tag`  out  1  requester index of the held result
- `i_res_ready`  in  1  consumer accepts the result this cycle

## Operation
- ALU opcodes are those of `seg_execute_alu`:
  - 0000 AND, 0001 OR, 0010 ADDU, 0011 ADDI, 0110 SUBU, 0111 SLT
  - 1000 LUI, 1001 XOR, 1010 NOR, 1011 SLL, 1100 SRL, 1101 SRA
  - Unlisted codes give the ALU's default result. The arbiter passes them through unchanged.
- One instance of `seg_execute_alu`. Its inputs are muxed from the selected port; the mux select equals the granted port.
- `can_accept = !o_valid || i_res_ready`.
- Selection:
  - If only one port requests, that port is selected.
  - If both request, the port named by the round-robin pointer `prio` is selected.
  - `o_gnt_x = i_req_x && selected_x && can_accept`. This is combinational, and at most one grant is high.
- On a grant edge:
  - result register ← ALUOut
  - `o_zero` ← (ALUOut == 0)
  - `o_tag` ← granted port
  - `o_valid` ← 1
  - `prio` ← other port
- Result handling:
  - If `o_valid && i_res_ready` with no new grant, `o_valid` ← 0.
  - If a result is consumed and a new grant happens in the same cycle, the new result replaces the old one and `o_valid` stays 1.
  - If `o_valid && !i_res_ready`, the register holds and grants are 0.
- State machine:
  - EMPTY (`o_valid=0`): goes to FULL on a grant.
  - FULL (`o_valid=1`): stays FULL on stall or on consume+grant; goes to EMPTY on consume with no grant.
- `prio` changes only on a grant. A lone request does not starve the other port, because `prio` always flips after a grant.
- Requesters must hold their operands and opcode stable while the request is high and ungranted. The arbiter samples them only on the grant edge.

## Timing
- Reset values (applied on the first edge with `i_reset=1`, regardless of state):
  - `o_valid=0`, `o_result=0`, `o_zero=0`, `o_tag=0`, `prio=0`.
  - Grants are low whenever `i_reset=1`.
- Latency: grant at edge N → result visible with `o_valid=1` after edge N.
- Throughput: one result per cycle while `i_res_ready=1`.
- A result held under backpressure is stable (value, zero flag and tag) until consumed.
- Reset during FULL: the held result is discarded. No grant is issued in the reset cycle.
- Simultaneous requests after reset: port 0 wins first.

## Test plan
- Reset: assert `i_reset` with both requests high and `i_res_ready=1` → grants 0. After release: `o_valid=0`, `o_result=0`, `o_tag=0`.
- Single request, port 0, ADDU:
  - Stimulus: `i_req_0=1`, ctl 0010, a=5, b=7, `i_res_ready=1`.
  - Response: `o_gnt_0=1`. Next cycle `o_valid=1`, `o_result=12`, `o_zero=0`, `o_tag=0`.
- Simultaneous requests after reset:
  - Port 0: AND with a=0x00001111, b=0x11110000. Port 1: SUBU with a=10, b=3.
  - Response: port 0 is granted first (result 0, `o_zero=1`, tag 0). Port 1 is granted the next cycle (result 7, tag 1).
- Backpressure:
  - Stimulus: `i_res_ready=0` with port 1 requesting SLL, a=0x00001111, b=2.
  - Response: `o_result=0x00004444` is held for 3 cycles with no grants. Raising `i_res_ready` consumes it and grants the pending request in the same cycle.
- Sustained contention: both ports request SLT (a=3, b=2) continuously with `i_res_ready=1` → tags alternate 0,1,0,1, every result is 0, and `o_zero=1`.
- Reset mid-operation: assert `i_reset` while FULL and stalled → `o_valid=0` after the edge, and `prio` returns to 0.

Source files
------------

// File: rtl/seg_execute_alu_arbiter_if.sv
// Request/result bundle for the shared execute-stage ALU arbiter.
// The two requesters and the result consumer sit on the master side.
// The arbiter sits on the slave side.
interface seg_execute_alu_arbiter_if #(
    parameter int LEN       = 32,
    parameter int NB_ALUCTL = 4
) ();
    logic                 i_req_0;
    logic                 i_req_1;
    logic [NB_ALUCTL-1:0] i_ALUctl_0;
    logic [NB_ALUCTL-1:0] i_ALUctl_1;
    logic [LEN-1:0]       i_data_a_0;
    logic [LEN-1:0]       i_data_a_1;
    logic [LEN-1:0]       i_data_b_0;
    logic [LEN-1:0]       i_data_b_1;
    logic                 o_gnt_0;
    logic                 o_gnt_1;
    logic                 o_valid;
    logic [LEN-1:0]       o_result;
    logic                 o_zero;
    logic                 o_tag;
    logic                 i_res_ready;

    modport master (
        output i_req_0, i_req_1, i_ALUctl_0, i_ALUctl_1,
        output i_data_a_0, i_data_a_1, i_data_b_0, i_data_b_1,
        output i_res_ready,
        input  o_gnt_0, o_gnt_1, o_valid, o_result, o_zero, o_tag
    );

    modport slave (
        input  i_req_0, i_req_1, i_ALUctl_0, i_ALUctl_1,
        input  i_data_a_0, i_data_a_1, i_data_b_0, i_data_b_1,
        input  i_res_ready,
        output o_gnt_0, o_gnt_1, o_valid, o_result, o_zero, o_tag
    );
endinterface

// File: rtl/seg_execute_alu_arbiter.sv
// Round-robin arbiter sharing one execute-stage ALU between the pipeline
// (port 0) and the debug/auxiliary path (port 1).
// The outcome is captured in a one-deep tagged result register that has a
// valid/ready output.
module seg_execute_alu_arbiter #(
    parameter int LEN       = 32,
    parameter int NB_ALUCTL = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    seg_execute_alu_arbiter_if.slave  bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t               state_r;
    logic                 valid_r;
    logic                 prio_r;
    logic                 zero_r;
    logic                 tag_r;
    logic [LEN-1:0]       result_r;

    logic                 sel_s;
    logic                 can_accept_s;
    logic                 gnt_0_s;
    logic                 gnt_1_s;
    logic                 grant_s;
    logic [NB_ALUCTL-1:0] alu_ctl_s;
    logic [LEN-1:0]       alu_a_s;
    logic [LEN-1:0]       alu_b_s;
    logic [LEN-1:0]       alu_out_s;

    // Choose the port to serve: a lone requester wins; under contention the pointer decides
    always_comb begin
        sel_s = 1'b0;
        if (bus.i_req_0 && bus.i_req_1) begin
            sel_s = prio_r;
        end else if (bus.i_req_1) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Grant only when the result register can take a new value; never during reset
    always_comb begin
        can_accept_s = !valid_r || bus.i_res_ready;
        gnt_0_s      = !i_reset && can_accept_s && bus.i_req_0 && !sel_s;
        gnt_1_s      = !i_reset && can_accept_s && bus.i_req_1 &&  sel_s;
        grant_s      = gnt_0_s || gnt_1_s;
    end

    // Steer the selected port's opcode and operands into the shared ALU
    always_comb begin
        if (sel_s) begin
            alu_ctl_s = bus.i_ALUctl_1;
            alu_a_s   = bus.i_data_a_1;
            alu_b_s   = bus.i_data_b_1;
        end else begin
            alu_ctl_s = bus.i_ALUctl_0;
            alu_a_s   = bus.i_data_a_0;
            alu_b_s   = bus.i_data_b_0;
        end
    end

    seg_execute_alu #(
        .LEN       (LEN),
        .NB_ALUCTL (NB_ALUCTL)
    ) u_alu (
        .i_ALUctl (alu_ctl_s),
        .i_data_a (alu_a_s),
        .i_data_b (alu_b_s),
        .o_ALUOut (alu_out_s)
    );

    // Result-register FSM: capture on grant, drain on consume, hold under backpressure
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_EMPTY;
            valid_r  <= 1'b0;
            result_r <= {LEN{1'b0}};
            zero_r   <= 1'b0;
            tag_r    <= 1'b0;
            prio_r   <= 1'b0;
        end else begin
            if (grant_s) begin
                result_r <= alu_out_s;
                zero_r   <= (alu_out_s == {LEN{1'b0}});
                tag_r    <= sel_s;
                prio_r   <= ~sel_s;
            end else begin
                result_r <= result_r;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (grant_s) begin
                        state_r <= ST_FULL;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (grant_s || !bus.i_res_ready) begin
                        state_r <= ST_FULL;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_gnt_0  = gnt_0_s;
    assign bus.o_gnt_1  = gnt_1_s;
    assign bus.o_valid  = valid_r;
    assign bus.o_result = result_r;
    assign bus.o_zero   = zero_r;
    assign bus.o_tag    = tag_r;
endmodule

// Combinational MIPS execute ALU; unlisted opcodes produce zero.
module seg_execute_alu #(
    parameter int LEN       = 32,
    parameter int NB_ALUCTL = 4
) (
    input  logic [NB_ALUCTL-1:0] i_ALUctl,
    input  logic [LEN-1:0]       i_data_a,
    input  logic [LEN-1:0]       i_data_b,
    output logic [LEN-1:0]       o_ALUOut
);
    localparam int NB_SHAMT = $clog2(LEN);
    localparam int HALF     = LEN / 2;

    logic [NB_SHAMT-1:0] shamt_s;

    // Decode the operation; shifts take their amount from the low bits of operand B
    always_comb begin
        shamt_s  = i_data_b[NB_SHAMT-1:0];
        o_ALUOut = {LEN{1'b0}};
        case (i_ALUctl)
            4'b0000: o_ALUOut = i_data_a & i_data_b;
            4'b0001: o_ALUOut = i_data_a | i_data_b;
            4'b0010: o_ALUOut = i_data_a + i_data_b;
            4'b0011: o_ALUOut = i_data_a + i_data_b;
            4'b0110: o_ALUOut = i_data_a - i_data_b;
            4'b0111: o_ALUOut = {{(LEN-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            4'b1000: o_ALUOut = {i_data_b[HALF-1:0], {HALF{1'b0}}};
            4'b1001: o_ALUOut = i_data_a ^ i_data_b;
            4'b1010: o_ALUOut = ~(i_data_a | i_data_b);
            4'b1011: o_ALUOut = i_data_a << shamt_s;
            4'b1100: o_ALUOut = i_data_a >> shamt_s;
            4'b1101: o_ALUOut = $signed(i_data_a) >>> shamt_s;
            default: o_ALUOut = {LEN{1'b0}};
        endcase
    end
endmodule

// File: tb/tb_seg_execute_alu_arbiter.sv
// Bench for seg_execute_alu_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the arbiter and result register.
module tb_seg_execute_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic en = 1'b0;

    seg_execute_alu_arbiter_if #(.LEN(32), .NB_ALUCTL(4)) bus ();

    seg_execute_alu_arbiter #(.LEN(32), .NB_ALUCTL(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model state
    logic        m_valid, m_zero, m_tag, m_prio;
    logic [31:0] m_result;
    logic        g_last_0 = 1'b0;
    logic        g_last_1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(b[4:0]);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2, 4'h3: return a + b;
            4'h6: return a - b;
            4'h7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h8: return b * 32'd65536;
            4'h9: return a ^ b;
            4'hA: return ~(a | b);
            4'hB: return a << sa;
            4'hC: return a >> sa;
            4'hD: return a[31] ? ~((~a) >> sa) : (a >> sa);
            default: return 32'd0;
        endcase
    endfunction

    // Which port the arbiter must grant this cycle, -1 for none
    function automatic int exp_winner();
        if (rst) return -1;
        if (m_valid && !bus.i_res_ready) return -1;
        if (bus.i_req_0 && bus.i_req_1) return m_prio ? 1 : 0;
        if (bus.i_req_0) return 0;
        if (bus.i_req_1) return 1;
        return -1;
    endfunction

    // Model update on each rising edge
    always @(posedge clk) begin
        int w;
        logic [31:0] r;
        w = exp_winner();
        if (rst) begin
            m_valid  <= 1'b0;
            m_result <= 32'd0;
            m_zero   <= 1'b0;
            m_tag    <= 1'b0;
            m_prio   <= 1'b0;
        end else if (w >= 0) begin
            r = (w == 1) ? alu_ref(bus.i_ALUctl_1, bus.i_data_a_1, bus.i_data_b_1)
                         : alu_ref(bus.i_ALUctl_0, bus.i_data_a_0, bus.i_data_b_0);
            m_result <= r;
            m_zero   <= (r == 32'd0);
            m_tag    <= (w == 1);
            m_valid  <= 1'b1;
            m_prio   <= (w == 0);
        end else if (bus.i_res_ready) begin
            m_valid <= 1'b0;
        end
        g_last_0 <= (w == 0);
        g_last_1 <= (w == 1);
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (en) begin
            int w;
            w = exp_winner();
            chk("gnt_0",  bus.o_gnt_0,  (w == 0));
            chk("gnt_1",  bus.o_gnt_1,  (w == 1));
            chk("valid",  bus.o_valid,  m_valid);
            chk("result", bus.o_result, m_result);
            chk("zero",   bus.o_zero,   m_zero);
            chk("tag",    bus.o_tag,    m_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_req_0 = r; bus.i_ALUctl_0 = op; bus.i_data_a_0 = a; bus.i_data_b_0 = b;
    endtask

    task automatic set_req1(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_req_1 = r; bus.i_ALUctl_1 = op; bus.i_data_a_1 = a; bus.i_data_b_1 = b;
    endtask

    initial begin
        bus.i_res_ready = 1'b1;
        set_req0(1'b1, 4'h2, 32'd1, 32'd1);
        set_req1(1'b1, 4'h2, 32'd2, 32'd2);

        // Reset with both requests high: no grants
        rst = 1'b1;
        step();
        en = 1'b1;
        @(negedge clk);
        chk("rst_gnt_0", bus.o_gnt_0, 32'd0);
        chk("rst_gnt_1", bus.o_gnt_1, 32'd0);
        step();
        rst = 1'b0;
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        set_req1(1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rst_valid",  bus.o_valid,  32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_tag",    bus.o_tag,    32'd0);

        // Single request port 0, ADDU 5+7
        set_req0(1'b1, 4'b0010, 32'd5, 32'd7);
        @(negedge clk);
        chk("addu_gnt0", bus.o_gnt_0, 32'd1);
        step();
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("addu_valid",  bus.o_valid,  32'd1);
        chk("addu_result", bus.o_result, 32'd12);
        chk("addu_zero",   bus.o_zero,   32'd0);
        chk("addu_tag",    bus.o_tag,    32'd0);

        // Reset, then simultaneous AND (port 0) and SUBU (port 1)
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req0(1'b1, 4'b0000, 32'h0000_1111, 32'h1111_0000);
        set_req1(1'b1, 4'b0110, 32'd10, 32'd3);
        @(negedge clk);
        chk("sim_gnt0_first", bus.o_gnt_0, 32'd1);
        chk("sim_gnt1_wait",  bus.o_gnt_1, 32'd0);
        step();
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("sim_and_result", bus.o_result, 32'd0);
        chk("sim_and_zero",   bus.o_zero,   32'd1);
        chk("sim_and_tag",    bus.o_tag,    32'd0);
        chk("sim_gnt1_next",  bus.o_gnt_1,  32'd1);
        step();
        // Port 1 SLL issued while SUBU result drains
        set_req1(1'b1, 4'b1011, 32'h0000_1111, 32'd2);
        @(negedge clk);
        chk("sim_sub_result", bus.o_result, 32'd7);
        chk("sim_sub_tag",    bus.o_tag,    32'd1);
        chk("bp_sll_gnt1",    bus.o_gnt_1,  32'd1);
        step();

        // Backpressure: SLL result held for 3 cycles while port 0 waits
        set_req1(1'b0, 4'h0, 32'd0, 32'd0);
        set_req0(1'b1, 4'b0010, 32'd1, 32'd1);
        bus.i_res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_result", bus.o_result, 32'h0000_4444);
            chk("bp_hold_tag",    bus.o_tag,    32'd1);
            chk("bp_hold_gnt0",   bus.o_gnt_0,  32'd0);
            step();
        end
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_gnt0", bus.o_gnt_0, 32'd1);
        step();
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        @(negedge clk);
        chk("bp_new_result", bus.o_result, 32'd2);
        chk("bp_new_tag",    bus.o_tag,    32'd0);

        // Sustained contention with SLT 3<2: alternating tags, zero results
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req0(1'b1, 4'b0111, 32'd3, 32'd2);
        set_req1(1'b1, 4'b0111, 32'd3, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("rr_tag",    bus.o_tag,    i % 2);
            chk("rr_result", bus.o_result, 32'd0);
            chk("rr_zero",   bus.o_zero,   32'd1);
        end
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        set_req1(1'b0, 4'h0, 32'd0, 32'd0);
        step();

        // Reset while FULL and stalled
        set_req0(1'b1, 4'b0010, 32'd1, 32'd2);
        step();
        set_req0(1'b0, 4'h0, 32'd0, 32'd0);
        bus.i_res_ready = 1'b0;
        step();
        @(negedge clk);
        chk("mid_full_valid", bus.o_valid, 32'd1);
        rst = 1'b1;
        bus.i_res_ready = 1'b1;
        set_req1(1'b1, 4'b0010, 32'd4, 32'd4);
        @(negedge clk);
        chk("mid_rst_gnt1", bus.o_gnt_1, 32'd0);
        step();
        rst = 1'b0;
        set_req0(1'b1, 4'b0010, 32'd4, 32'd4);
        @(negedge clk);
        chk("mid_rst_valid", bus.o_valid, 32'd0);
        chk("mid_prio_gnt0", bus.o_gnt_0, 32'd1);
        step();

        // Randomized traffic: requests are held until granted, ready and reset vary
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.i_res_ready = ($urandom_range(0, 9) < 7);
            if (!bus.i_req_0 || g_last_0) begin
                if ($urandom_range(0, 9) < 6)
                    set_req0(1'b1, 4'($urandom_range(0, 15)),
                             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), $urandom());
                else
                    set_req0(1'b0, 4'h0, 32'd0, 32'd0);
            end
            if (!bus.i_req_1 || g_last_1) begin
                if ($urandom_range(0, 9) < 6)
                    set_req1(1'b1, 4'($urandom_range(0, 15)),
                             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), $urandom());
                else
                    set_req1(1'b0, 4'h0, 32'd0, 32'd0);
            end
            step();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
